// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG zigzag reorder block.
// ZIGZAG_EOB_EN adds the zero-fill state used after an early end-of-block.
package jpeg_pkg;

  localparam int COEF_W = 12;
  localparam int BLK_N  = 64;
  localparam int ADDR_W = 7;   // {bank, 6-bit position}

  // Zigzag scan index -> raster index ({row, col}).
  localparam logic [5:0] ZZ_LUT [BLK_N] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

`ifdef ZIGZAG_EOB_EN
  typedef enum logic {WR_WRITE = 1'b0, WR_FILL = 1'b1} wr_state_e;
`else
  typedef enum logic {WR_WRITE = 1'b0} wr_state_e;
`endif

endpackage

// File: rtl/zz_buf_mem.sv
// Ping-pong coefficient store: 2 banks x 64 entries, one write port,
// one read port with a registered (1-cycle) read.
module zz_buf_mem
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem_q [2*BLK_N];
  logic [COEF_W-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/zigzag_reorder.sv
// Zigzag-to-raster coefficient reorder with ping-pong buffering.
// Writes land at their raster position; reads walk raster order.
// Define ZIGZAG_EOB_EN to add the in_eob port and zero-fill state.
module zigzag_reorder
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
`ifdef ZIGZAG_EOB_EN
  input  logic              in_eob,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_last
);

  // write side
  logic [5:0]  k_q, k_d;
  logic        wbank_q, wbank_d;
  logic [1:0]  full_q, full_d;
  logic        fill_active, in_ready_int, in_hs, mem_we, blk_done;
  logic [COEF_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_waddr;
  // read side
  logic        rbank_q, rbank_d;
  logic [5:0]  r_q, r_d;
  logic        rd_done_q, rd_done_d;
  logic        pend_q, pend_d, pend_last_q, pend_last_d;
  logic        rd_issue, pop, last_hs;
  logic [2:0]  occ, occ_lim;
  logic [COEF_W-1:0] mem_rdata;
  // two-entry output skid: {last, data}
  logic [COEF_W:0] s0_q, s0_d, s1_q, s1_d, push_val;
  logic [1:0]  cnt_q, cnt_d, wr_idx;

`ifdef ZIGZAG_EOB_EN
  wr_state_e   state_q, state_d;
  assign fill_active  = (state_q == WR_FILL);
  assign in_ready_int = (state_q == WR_WRITE) && !full_q[wbank_q];
`else
  assign fill_active  = 1'b0;
  assign in_ready_int = !full_q[wbank_q];
`endif

  // Ready is forced low while reset is held.
  assign in_ready  = rst & in_ready_int;
  assign in_hs     = in_valid & in_ready;
  assign mem_we    = in_hs | fill_active;
  assign mem_wdata = fill_active ? '0 : in_data;
  assign mem_waddr = {wbank_q, ZZ_LUT[k_q]};
  assign blk_done  = mem_we && (k_q == 6'd63);

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = s0_q[COEF_W-1:0];
  assign out_last  = s0_q[COEF_W] & out_valid;
  assign pop       = out_valid & out_ready;
  assign last_hs   = pop & s0_q[COEF_W];
  assign push_val  = {pend_last_q, mem_rdata};

  // Only issue a read when the skid plus in-flight read leave room for it.
  assign occ      = {1'b0, cnt_q} + {2'b00, pend_q};
  assign occ_lim  = 3'd2 + {2'b00, pop};
  assign rd_issue = full_q[rbank_q] && !rd_done_q && (occ < occ_lim);

  zz_buf_mem u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (rd_issue),
    .rd_addr ({rbank_q, r_q}),
    .rd_data (mem_rdata)
  );

  // Write counter, bank select and (optional) zero-fill state.
  always_comb begin
    k_d     = k_q;
    wbank_d = wbank_q;
    if (mem_we) begin
      k_d = k_q + 6'd1;
      if (blk_done) wbank_d = ~wbank_q;
    end
`ifdef ZIGZAG_EOB_EN
    state_d = state_q;
    if (fill_active && (k_q == 6'd63))          state_d = WR_WRITE;
    else if (in_hs && in_eob && (k_q != 6'd63)) state_d = WR_FILL;
`endif
  end

  // Read counter, bank flags; set and clear on one edge both apply.
  always_comb begin
    r_d         = r_q;
    rd_done_d   = rd_done_q;
    rbank_d     = rbank_q;
    pend_d      = rd_issue;
    pend_last_d = rd_issue && (r_q == 6'd63);
    full_d      = full_q;
    if (rd_issue) begin
      r_d = r_q + 6'd1;
      if (r_q == 6'd63) rd_done_d = 1'b1;
    end
    if (last_hs) begin
      rd_done_d       = 1'b0;
      rbank_d         = ~rbank_q;
      full_d[rbank_q] = 1'b0;
    end
    if (blk_done) full_d[wbank_q] = 1'b1;
  end

  // Skid update: pop shifts the head, then returning read data lands behind.
  always_comb begin
    s0_d   = s0_q;
    s1_d   = s1_q;
    if (pop) s0_d = s1_q;
    wr_idx = cnt_q - {1'b0, pop};
    if (pend_q) begin
      if (wr_idx == 2'd0) s0_d = push_val;
      else                s1_d = push_val;
    end
    cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
  end

  // Write-side state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q     <= '0;
      wbank_q <= 1'b0;
`ifdef ZIGZAG_EOB_EN
      state_q <= WR_WRITE;
`endif
    end else begin
      k_q     <= k_d;
      wbank_q <= wbank_d;
`ifdef ZIGZAG_EOB_EN
      state_q <= state_d;
`endif
    end
  end

  // Read-side and bank-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= 2'b00;
      rbank_q     <= 1'b0;
      r_q         <= '0;
      rd_done_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      rbank_q     <= rbank_d;
      r_q         <= r_d;
      rd_done_q   <= rd_done_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  // Output skid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Scoreboard bench for zigzag_reorder: a block model computes raster order
// from a diagonal walk; a monitor pops expected outputs on each handshake.
module tb_zigzag_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_eob_s = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last;
  logic [11:0] out_data;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random
  int blocks_queued = 0;

  logic [12:0] exp_q [$];
  int          zz_pos [64];
  logic [11:0] blk_smp [64];
  int          blk_k = 0;

  zigzag_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef ZIGZAG_EOB_EN
    .in_eob    (in_eob_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Zigzag order by walking anti-diagonals, alternating direction.
  task automatic build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin zz_pos[idx] = row * 8 + (s - row); idx++; end
      end else begin
        for (int row = lo; row <= hi; row++) begin zz_pos[idx] = row * 8 + (s - row); idx++; end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Completed block -> expected raster-order outputs.
  task automatic push_block();
    logic [11:0] ras [64];
    for (int k = 0; k < 64; k++) ras[zz_pos[k]] = blk_smp[k];
    for (int r = 0; r < 64; r++) exp_q.push_back({(r == 63), ras[r]});
    blocks_queued++;
    $display("block %0d queued, first raster value %0d", blocks_queued, ras[0]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [11:0] d, input logic eob);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_eob_s = eob;
    @(negedge clk);
    while (!in_ready && n < 3000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end else begin
      blk_smp[blk_k] = d;
      if (eob || blk_k == 63) begin
        for (int j = blk_k + 1; j < 64; j++) blk_smp[j] = '0;
        push_block();
        blk_k = 0;
      end else blk_k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_eob_s = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    chk("drain_remaining", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // out_ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stall stability and in-order scoreboard compare.
  initial begin
    logic        prev_stall = 1'b0;
    logic [12:0] prev_out = '0;
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || {out_last, out_data} !== prev_out) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, {out_last, out_data}, prev_out);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_output: got %h expected no output", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              errors++;
              $display("FAIL out_seq: got last=%0b data=%0d expected last=%0b data=%0d",
                       out_last, out_data, e[12], e[11:0]);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_last, out_data};
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zz();
    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // ramp block, plus first-output latency
    ready_mode = 1;
    for (int k = 0; k < 64; k++) send(12'(k), 1'b0);
    @(negedge clk); chk("lat_cyc0_valid", out_valid, 0);
    @(negedge clk); chk("lat_cyc1_valid", out_valid, 0);
    @(negedge clk); chk("lat_cyc2_valid", out_valid, 1);
    chk("lat_first_data", out_data, 0);
    drain();

    // both banks full with output stalled, then release
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 128; i++) send(12'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    chk("both_full_in_ready", in_ready, 0);
    chk("both_full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 64; i++) send(12'($urandom), 1'b0);
      begin repeat (10) @(posedge clk); #1; ready_mode = 1; end
    join
    drain();

    // random backpressure and input gaps
    ready_mode = 2;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 64; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(12'($urandom), 1'b0);
      end
    ready_mode = 1;
    drain();

    // free bank 0 on the same edge bank 1 fills
    for (int i = 0; i < 64; i++) send(12'($urandom), 1'b0);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 64; i++) send(12'($urandom), 1'b0);
    @(negedge clk);
    chk("same_edge_in_ready", in_ready, 1);
    drain();

    // reset in the middle of the second block
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 94; i++) send(12'($urandom), 1'b0);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b0; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    blk_k = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ready_mode = 1;
    for (int i = 0; i < 64; i++) send(12'($urandom), 1'b0);
    drain();
    repeat (5) @(negedge clk);
    chk("post_rst_idle", out_valid, 0);

`ifdef ZIGZAG_EOB_EN
    // early end-of-block with zero fill
    begin
      int n = 0;
      send(12'd10, 1'b0);
      send(12'd20, 1'b0);
      send(12'd30, 1'b1);
      @(negedge clk);
      while (!in_ready && n < 200) begin n++; @(negedge clk); end
      chk("eob_ready_low_cycles", n, 61);
      @(posedge clk); #1;
      drain();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
